data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/dmem_pkg.sv | 7 +
 rtl/dmem_byte_merge.sv | 17 +
 rtl/data_memory.sv | 62 ++++++
 tb/tb_data_memory.sv | 114 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: default geometry and word type shared by the data memory and its bench
package dmem_pkg;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 256;
    typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/dmem_byte_merge.sv
// dmem_byte_merge: overlays the strobed bytes of value onto old_word
module dmem_byte_merge
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   value,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   new_word
);
    always_comb begin
        new_word = old_word;
        for (int k = 0; k < DATA_W/8; k++)
            if (byte_en[k]) new_word[8*k +: 8] = value[8*k +: 8];
    end
endmodule

// File: rtl/data_memory.sv
// data_memory: word-addressed RAM, combinational read, byte-strobed synchronous write.
// Define DATA_MEMORY_PRELOAD_EN to make reset load word i with i instead of 0.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   Address,
    input  logic [DATA_W-1:0]   Value,
    input  logic                isStore,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic [DATA_W-1:0]   DMoutput,
    output logic                AddrErr
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef DATA_MEMORY_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    function automatic logic [DATA_W-1:0] reset_word(input int i);
        return PRELOAD ? DATA_W'(i) : '0;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] new_word;

    dmem_byte_merge #(.DATA_W(DATA_W)) u_merge (
        .old_word (old_word),
        .value    (Value),
        .byte_en  (ByteEn),
        .new_word (new_word)
    );

    // Out-of-range addresses read as zero and never write, even though idx aliases a real word
    always_comb begin
        in_range = {1'b0, Address} < (ADDR_W+1)'(DEPTH);
        idx      = Address[IDX_W-1:0];
        old_word = in_range ? mem_q[idx] : '0;
        DMoutput = old_word;
        AddrErr  = !in_range;
        mem_d    = mem_q;
        if (isStore && in_range) mem_d[idx] = new_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= reset_word(i);
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed checks on a default-size memory and a 16-word memory sharing inputs
module tb_data_memory;
    import dmem_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Address;
    word_t      Value;
    logic       isStore;
    logic [7:0] ByteEn;
    word_t      dout_a, dout_b;
    logic       err_a, err_b;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    data_memory u_a (
        .clk(clk), .reset(reset), .Address(Address), .Value(Value),
        .isStore(isStore), .ByteEn(ByteEn), .DMoutput(dout_a), .AddrErr(err_a)
    );

    data_memory #(.DEPTH(16)) u_b (
        .clk(clk), .reset(reset), .Address(Address), .Value(Value),
        .isStore(isStore), .ByteEn(ByteEn), .DMoutput(dout_b), .AddrErr(err_b)
    );

    function automatic word_t rst_val(input int i);
`ifdef DATA_MEMORY_PRELOAD_EN
        return word_t'(i);
`else
        return i < 0 ? word_t'(1) : '0;
`endif
    endfunction

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; isStore = 1'b1; Address = 8'd5; Value = 64'hF; ByteEn = 8'hFF;
        step();
        reset = 1'b0; isStore = 1'b0;
        #1;
        check("rst_beats_wr_a", dout_a, rst_val(5));
        check("rst_beats_wr_b", dout_b, rst_val(5));
        Address = 8'h17; #1;
        check("rst_17_a", dout_a, rst_val(8'h17));
        check("rst_17_err_a", word_t'(err_a), 0);
        check("oor_17_b", dout_b, 0);
        check("oor_17_err_b", word_t'(err_b), 1);
        Address = 8'hFF; #1;
        check("rst_ff_a", dout_a, rst_val(8'hFF));
        check("rst_ff_err_a", word_t'(err_a), 0);

        Address = 8'h17; Value = 64'h9; ByteEn = 8'hFF; isStore = 1'b1; #1;
        check("rdw_old", dout_a, rst_val(8'h17));
        step();
        isStore = 1'b0; #1;
        check("full_wr", dout_a, 64'h9);

        Address = 8'h30; Value = 64'h1122334455667788; isStore = 1'b1;
        step();
        Value = 64'hAAAAAAAAAAAAAAAA; ByteEn = 8'h81;
        step();
        isStore = 1'b0; #1;
        check("byte_wr", dout_a, 64'hAA223344556677AA);
        Value = '1; ByteEn = 8'h00; isStore = 1'b1;
        step();
        isStore = 1'b0; #1;
        check("zero_strobe", dout_a, 64'hAA223344556677AA);
        Value = 64'h0102030405060708; ByteEn = 8'h3C; isStore = 1'b1;
        step();
        isStore = 1'b0; #1;
        check("mid_bytes", dout_a, 64'hAA220304050677AA);

        Address = 8'd4; Value = 64'hDEAD; ByteEn = 8'hFF; isStore = 1'b1;
        step();
        isStore = 1'b0; #1;
        check("b_w4", dout_b, 64'hDEAD);
        check("b_w4_err", word_t'(err_b), 0);
        Address = 8'd20; Value = 64'hF; isStore = 1'b1; #1;
        check("oor20_err_b", word_t'(err_b), 1);
        check("oor20_dout_b", dout_b, 0);
        step();
        isStore = 1'b0; #1;
        check("a_w20", dout_a, 64'hF);
        Address = 8'd4; #1;
        check("b_mem4_kept", dout_b, 64'hDEAD);
        Address = 8'd15; #1;
        check("b_last_err", word_t'(err_b), 0);
        Address = 8'd16; #1;
        check("b_first_oor", word_t'(err_b), 1);

        reset = 1'b1; Address = 8'h17;
        step();
        reset = 1'b0; #1;
        check("rerst_17_a", dout_a, rst_val(8'h17));
        Address = 8'h30; #1;
        check("rerst_30_a", dout_a, rst_val(8'h30));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
